// File: rtl/alu_arb_ctrl.sv
// Round-robin arbiter between two requesters sharing one multi-unit ALU.
// One operation in flight; the selected unit's flag completes it, a timeout aborts it.
module alu_arb_ctrl #(
   parameter int OP_DATA_WIDTH = 16,
   parameter int RES_WIDTH     = 2*OP_DATA_WIDTH,
   parameter int TIMEOUT       = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req0_valid,
   output logic                     req0_ready,
   input  logic [OP_DATA_WIDTH-1:0] req0_a,
   input  logic [OP_DATA_WIDTH-1:0] req0_b,
   input  logic [3:0]               req0_fun,
   input  logic                     req1_valid,
   output logic                     req1_ready,
   input  logic [OP_DATA_WIDTH-1:0] req1_a,
   input  logic [OP_DATA_WIDTH-1:0] req1_b,
   input  logic [3:0]               req1_fun,
   output logic [OP_DATA_WIDTH-1:0] alu_a,
   output logic [OP_DATA_WIDTH-1:0] alu_b,
   output logic [3:0]               alu_fun,
   input  logic [RES_WIDTH-1:0]     alu_arith_out,
   input  logic                     alu_carry,
   input  logic [OP_DATA_WIDTH-1:0] alu_logic_out,
   input  logic [OP_DATA_WIDTH-1:0] alu_shift_out,
   input  logic [1:0]               alu_cmp_out,
   input  logic                     alu_arith_flag,
   input  logic                     alu_logic_flag,
   input  logic                     alu_cmp_flag,
   input  logic                     alu_shift_flag,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic                     rsp_id,
   output logic [RES_WIDTH-1:0]     rsp_data,
   output logic                     rsp_carry,
   output logic                     rsp_err
);
   // state | meaning
   // IDLE  | wait for a request; the grant cycle stays in IDLE with one READY high
   // ISSUE | operands stable on the ALU ports, ALU samples them, timer cleared
   // WAIT  | watch the selected unit's flag, count toward timeout
   // RESP  | response held until rsp_ready
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t               state_q, state_d;
   logic [1:0]           ready_q;
   logic                 rr_ptr_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 grant_sel;
   logic                 sel_flag;
   logic                 do_grant, do_capture, do_timeout;
   logic [RES_WIDTH-1:0] cap_data;
   logic                 cap_carry;

   // READY is registered so no requester's VALID reaches the other's READY combinationally
   assign req0_ready = ready_q[0];
   assign req1_ready = ready_q[1];
   assign rsp_valid  = (state_q == RESP);
   assign grant_sel  = (req0_valid & req1_valid) ? ~rr_ptr_q : req1_valid;

   always_comb begin
      sel_flag  = 1'b0;
      cap_data  = '0;
      cap_carry = 1'b0;
      case (alu_fun[3:2])
         2'b00: begin
            sel_flag  = alu_arith_flag;
            cap_data  = alu_arith_out;
            cap_carry = alu_carry;
         end
         2'b01: begin
            sel_flag = alu_logic_flag;
            cap_data = RES_WIDTH'(alu_logic_out);
         end
         2'b10: begin
            sel_flag = alu_cmp_flag;
            cap_data = RES_WIDTH'(alu_cmp_out);
         end
         default: begin
            sel_flag = alu_shift_flag;
            cap_data = RES_WIDTH'(alu_shift_out);
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      do_grant   = 1'b0;
      do_capture = 1'b0;
      do_timeout = 1'b0;
      case (state_q)
         IDLE: begin
            if (ready_q != 2'b00)               state_d  = ISSUE;
            else if (req0_valid | req1_valid)   do_grant = 1'b1;
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (sel_flag) begin
               do_capture = 1'b1;
               state_d    = RESP;
            end else if (cnt_q == CNT_W'(TIMEOUT-1)) begin
               do_timeout = 1'b1;
               state_d    = RESP;
            end
         end
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q   <= 2'b00;
         rr_ptr_q  <= 1'b1;
         cnt_q     <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_fun   <= '0;
         rsp_id    <= 1'b0;
         rsp_data  <= '0;
         rsp_carry <= 1'b0;
         rsp_err   <= 1'b0;
      end else begin
         ready_q <= 2'b00;
         if (do_grant) begin
            ready_q  <= grant_sel ? 2'b10 : 2'b01;
            rr_ptr_q <= grant_sel;
            rsp_id   <= grant_sel;
            alu_a    <= grant_sel ? req1_a   : req0_a;
            alu_b    <= grant_sel ? req1_b   : req0_b;
            alu_fun  <= grant_sel ? req1_fun : req0_fun;
         end
         if (state_q == ISSUE)                 cnt_q <= '0;
         else if (state_q == WAIT && !sel_flag) cnt_q <= cnt_q + 1'b1;
         if (do_capture) begin
            rsp_data  <= cap_data;
            rsp_carry <= cap_carry;
            rsp_err   <= 1'b0;
         end else if (do_timeout) begin
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_err   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_arb_ctrl.sv
// Bench for alu_arb_ctrl: a stub ALU answers on the DUT's operand ports, and a
// transaction-level model predicts grant order, timing and response contents.
module tb_alu_arb_ctrl;
   localparam int OPW     = 16;
   localparam int RESW    = 32;
   localparam int TIMEOUT = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            req0_valid, req1_valid, req0_ready, req1_ready;
   logic [OPW-1:0]  req0_a, req0_b, req1_a, req1_b;
   logic [3:0]      req0_fun, req1_fun;
   logic [OPW-1:0]  alu_a, alu_b;
   logic [3:0]      alu_fun;
   logic [RESW-1:0] alu_arith_out;
   logic            alu_carry;
   logic [OPW-1:0]  alu_logic_out, alu_shift_out;
   logic [1:0]      alu_cmp_out;
   logic [3:0]      flags;
   logic            tb_carry;
   logic            rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_err;
   logic [RESW-1:0] rsp_data;

   int   checks = 0;
   int   failures = 0;
   logic ptr_m;

   always #5 clk = ~clk;

   alu_arb_ctrl #(.OP_DATA_WIDTH(OPW), .RES_WIDTH(RESW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_fun(req0_fun),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_fun(req1_fun),
      .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
      .alu_arith_out(alu_arith_out), .alu_carry(alu_carry),
      .alu_logic_out(alu_logic_out), .alu_shift_out(alu_shift_out), .alu_cmp_out(alu_cmp_out),
      .alu_arith_flag(flags[0]), .alu_logic_flag(flags[1]), .alu_cmp_flag(flags[2]), .alu_shift_flag(flags[3]),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err)
   );

   function automatic logic [31:0] f_arith(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
      logic signed [31:0] sa, sb;
      sa = {{16{a[15]}}, a};
      sb = {{16{b[15]}}, b};
      case (op)
         2'd0:    return sa + sb;
         2'd1:    return sa - sb;
         2'd2:    return sa * sb;
         default: return sa + sb + 32'sd1;
      endcase
   endfunction

   function automatic logic [15:0] f_logic(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
      case (op)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a ^ b;
         default: return ~a;
      endcase
   endfunction

   function automatic logic [1:0] f_cmp(input logic [15:0] a, input logic [15:0] b);
      return {($signed(a) < $signed(b)), (a == b)};
   endfunction

   function automatic logic [15:0] f_shift(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
      case (op)
         2'd0:    return a << b[3:0];
         2'd1:    return a >> b[3:0];
         2'd2:    return 16'($signed(a) >>> b[3:0]);
         default: return {a[14:0], a[15]};
      endcase
   endfunction

   // Stub ALU: responds to whatever operands the DUT drives
   always_comb begin
      alu_arith_out = f_arith(alu_a, alu_b, alu_fun[1:0]);
      alu_logic_out = f_logic(alu_a, alu_b, alu_fun[1:0]);
      alu_cmp_out   = f_cmp(alu_a, alu_b);
      alu_shift_out = f_shift(alu_a, alu_b, alu_fun[1:0]);
      alu_carry     = tb_carry;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // flag_dly: WAIT cycles with the selected flag low before it rises (>= TIMEOUT: never)
   task automatic do_txn(input logic v0, input logic v1,
                         input logic [15:0] a0, input logic [15:0] b0, input logic [3:0] f0,
                         input logic [15:0] a1, input logic [15:0] b1, input logic [3:0] f1,
                         input int flag_dly, input int hold, input bit noise, input bit cin, input bit keep);
      logic        g, ecarry, eerr;
      logic [15:0] ea, eb;
      logic [3:0]  ef;
      logic [31:0] edata;
      int          n, waits;
      g     = (v0 && v1) ? ~ptr_m : v1;
      ptr_m = g;
      ea    = g ? a1 : a0;
      eb    = g ? b1 : b0;
      ef    = g ? f1 : f0;
      req0_valid = v0; req0_a = a0; req0_b = b0; req0_fun = f0;
      req1_valid = v1; req1_a = a1; req1_b = b1; req1_fun = f1;
      tb_carry   = cin;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(req0_ready || req1_ready) && n < 8);
      chk("grant_latency", 64'(n), 64'd1);
      chk("grant_onehot", {req1_ready, req0_ready}, g ? 2'b10 : 2'b01);
      if (!keep) begin
         req0_valid = 1'b0;
         req1_valid = 1'b0;
      end
      @(negedge clk);
      chk("ready_one_cycle", {req1_ready, req0_ready}, 2'b00);
      chk("alu_a", alu_a, ea);
      chk("alu_b", alu_b, eb);
      chk("alu_fun", alu_fun, ef);
      waits = (flag_dly < TIMEOUT) ? flag_dly + 1 : TIMEOUT;
      for (int k = 0; k < waits; k++) begin
         @(negedge clk);
         chk("no_rsp_in_wait", rsp_valid, 1'b0);
         flags = noise ? 4'($urandom) : 4'b0000;
         flags[ef[3:2]] = (k == flag_dly);
      end
      @(negedge clk);
      flags = 4'b0000;
      ecarry = 1'b0;
      eerr   = 1'b0;
      case (ef[3:2])
         2'b00: begin
            edata  = f_arith(ea, eb, ef[1:0]);
            ecarry = cin;
         end
         2'b01:   edata = {16'b0, f_logic(ea, eb, ef[1:0])};
         2'b10:   edata = {30'b0, f_cmp(ea, eb)};
         default: edata = {16'b0, f_shift(ea, eb, ef[1:0])};
      endcase
      if (flag_dly >= TIMEOUT) begin
         edata  = '0;
         ecarry = 1'b0;
         eerr   = 1'b1;
      end
      for (int h = 0; h <= hold; h++) begin
         chk("rsp_valid", rsp_valid, 1'b1);
         chk("rsp_id", rsp_id, g);
         chk("rsp_data", rsp_data, edata);
         chk("rsp_carry", rsp_carry, ecarry);
         chk("rsp_err", rsp_err, eerr);
         if (h < hold) @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("rsp_drop", rsp_valid, 1'b0);
      chk("alu_a_hold", alu_a, ea);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"}, {req1_ready, req0_ready}, 2'b00);
      chk({tag, "_alu"}, {alu_a, alu_b, alu_fun}, 36'd0);
      chk({tag, "_rsp"}, {rsp_valid, rsp_id, rsp_carry, rsp_err, rsp_data}, 36'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1);
   end

   initial begin
      logic [1:0] v;
      int         n;
      rst_n = 1'b0; rsp_ready = 1'b0; flags = 4'b0; tb_carry = 1'b0;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_fun = '0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_fun = '0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      ptr_m = 1'b1;
      @(negedge clk);

      // both held valid: grants alternate 0,1,0,1
      do_txn(1, 1, 16'd10, 16'd20, 4'b0000, 16'd7, 16'd9, 4'b0001, 0, 0, 0, 0, 1);
      do_txn(1, 1, 16'd10, 16'd20, 4'b0000, 16'd7, 16'd9, 4'b0001, 1, 0, 0, 0, 1);
      do_txn(1, 1, 16'd10, 16'd20, 4'b0000, 16'd7, 16'd9, 4'b0001, 0, 1, 0, 0, 1);
      do_txn(1, 1, 16'd10, 16'd20, 4'b0000, 16'd7, 16'd9, 4'b0001, 2, 0, 0, 0, 0);

      // single requester add, 5 + -3
      do_txn(1, 0, 16'd5, -16'sd3, 4'b0000, 16'd0, 16'd0, 4'b0000, 0, 0, 0, 0, 0);
      // compare, consumer stalls for 5 cycles
      do_txn(1, 0, -16'sd7, 16'd3, 4'b1000, 16'd0, 16'd0, 4'b0000, 1, 5, 0, 0, 0);
      // selected flag never rises, other flags toggle
      do_txn(0, 1, 16'd0, 16'd0, 4'b0000, 16'h00f0, 16'h0ff0, 4'b0100, TIMEOUT, 1, 1, 1, 0);
      // carry passes only for arithmetic
      do_txn(1, 0, 16'h8000, 16'h0001, 4'b0001, 16'd0, 16'd0, 4'b0000, 0, 0, 0, 1, 0);
      do_txn(1, 0, 16'h1234, 16'h00ff, 4'b0100, 16'd0, 16'd0, 4'b0000, 0, 0, 0, 1, 0);

      // reset while waiting for the flag
      req0_valid = 1'b1; req0_a = 16'd3; req0_b = 16'd4; req0_fun = 4'b0000;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!req0_ready && n < 8);
      chk("rst_test_grant", 64'(n), 64'd1);
      req0_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_all_zero("mid_reset");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mid_reset_no_rsp", rsp_valid, 1'b0);
      end
      rst_n = 1'b1;
      ptr_m = 1'b1;
      do_txn(0, 1, 16'd0, 16'd0, 4'b0000, 16'd100, 16'd55, 4'b0001, 0, 0, 0, 0, 0);

      // randomized traffic
      for (int t = 0; t < 30; t++) begin
         v = 2'($urandom_range(1, 3));
         do_txn(v[0], v[1], 16'($urandom), 16'($urandom), 4'($urandom),
                16'($urandom), 16'($urandom), 4'($urandom),
                $urandom_range(0, TIMEOUT), $urandom_range(0, 3),
                1'($urandom), 1'($urandom), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
